// File: rtl/peripheral_divider.sv
// Memory-mapped unsigned restoring divider: one quotient bit per clock,
// software starts it through CTRL and polls the status bits for completion.
module peripheral_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] d_in,
  input  logic        cs,
  input  logic [4:0]  addr,
  input  logic        rd,
  input  logic        wr,
  output logic [31:0] d_out
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] dividend_reg;
  logic [WIDTH-1:0] divisor_reg;
  logic [WIDTH-1:0] quotient_reg;
  logic [WIDTH-1:0] remainder_reg;
  logic [WIDTH-1:0] work_dividend;
  logic [WIDTH-1:0] work_divisor;
  logic [WIDTH-1:0] rem_acc;
  logic [WIDTH-1:0] q_acc;
  logic [CNT_W-1:0] cnt;
  logic             busy;
  logic             done;
  logic             div0;

  logic [2:0]       reg_sel;
  logic             wr_en;
  logic             rd_en;
  logic             start;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] q_next;
  logic [31:0]      rd_data;

  assign reg_sel = addr[4:2];
  assign wr_en   = cs & wr;
  assign rd_en   = cs & rd;
  assign start   = wr_en && (reg_sel == 3'd2) && d_in[0] && (state != RUN);

  // rem_acc < divisor always holds, so a WIDTH+1 bit subtract gives a clean borrow in the top bit.
  assign trial    = {rem_acc, work_dividend[WIDTH-1]} - {1'b0, work_divisor};
  assign borrow   = trial[WIDTH];
  assign rem_next = borrow ? {rem_acc[WIDTH-2:0], work_dividend[WIDTH-1]} : trial[WIDTH-1:0];
  assign q_next   = {q_acc[WIDTH-2:0], ~borrow};

  always_comb begin
    rd_data = 32'd0;
    case (reg_sel)
      3'd0:    rd_data = 32'(dividend_reg);
      3'd1:    rd_data = 32'(divisor_reg);
      3'd2:    rd_data = {29'd0, div0, done, busy};
      3'd3:    rd_data = 32'(quotient_reg);
      3'd4:    rd_data = 32'(remainder_reg);
      default: rd_data = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      dividend_reg  <= '0;
      divisor_reg   <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      work_dividend <= '0;
      work_divisor  <= '0;
      rem_acc       <= '0;
      q_acc         <= '0;
      cnt           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      div0          <= 1'b0;
      d_out         <= 32'd0;
    end else begin
      if (rd_en)
        d_out <= rd_data;

      if (wr_en && reg_sel == 3'd0)
        dividend_reg <= d_in[WIDTH-1:0];
      if (wr_en && reg_sel == 3'd1)
        divisor_reg <= d_in[WIDTH-1:0];

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state         <= RUN;
            work_dividend <= dividend_reg;
            work_divisor  <= divisor_reg;
            rem_acc       <= '0;
            q_acc         <= '0;
            cnt           <= CNT_W'(WIDTH);
            busy          <= 1'b1;
            done          <= 1'b0;
            div0          <= (divisor_reg == '0);
          end
        end
        RUN: begin
          rem_acc       <= rem_next;
          q_acc         <= q_next;
          work_dividend <= work_dividend << 1;
          cnt           <= cnt - 1'b1;
          // The final step's results go straight to the result registers.
          if (cnt == CNT_W'(1)) begin
            state         <= DONE;
            quotient_reg  <= q_next;
            remainder_reg <= rem_next;
            busy          <= 1'b0;
            done          <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_peripheral_divider.sv
// Directed bench for peripheral_divider: a register-access vector table plus
// hand-written sequences for completion timing, restart, divide-by-zero and reset.
module tb_peripheral_divider;

  logic        clk;
  logic        rst;
  logic [31:0] d_in;
  logic        cs;
  logic [4:0]  addr;
  logic        rd;
  logic        wr;
  logic [31:0] d_out;

  int compared;
  int mismatched;

  localparam logic [4:0] A_DIVIDEND  = 5'h00;
  localparam logic [4:0] A_DIVISOR   = 5'h04;
  localparam logic [4:0] A_CTRL      = 5'h08;
  localparam logic [4:0] A_QUOTIENT  = 5'h0C;
  localparam logic [4:0] A_REMAINDER = 5'h10;

  typedef struct {
    bit          is_wr;
    logic [4:0]  a;
    logic [31:0] data;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[10];

  peripheral_divider #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .rst   (rst),
    .d_in  (d_in),
    .cs    (cs),
    .addr  (addr),
    .rd    (rd),
    .wr    (wr),
    .d_out (d_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One bus cycle: strobes held across one rising edge, released 1ns after it.
  task automatic applyStimulus(input bit do_wr, input bit do_rd, input bit sel,
                               input logic [4:0] a, input logic [31:0] data);
    cs   = sel;
    wr   = do_wr;
    rd   = do_rd;
    addr = a;
    d_in = data;
    @(posedge clk);
    #1;
    cs = 1'b0;
    wr = 1'b0;
    rd = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] data);
    applyStimulus(1'b1, 1'b0, 1'b1, a, data);
  endtask

  task automatic read_check(input string name, input logic [4:0] a, input logic [31:0] exp);
    applyStimulus(1'b0, 1'b1, 1'b1, a, 32'd0);
    checkOutput(name, d_out, exp);
  endtask

  // Polls CTRL until done is set, giving up after a fixed budget.
  task automatic wait_done(input string name);
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, A_CTRL, 32'd0);
      if (d_out[1]) break;
    end
    checkOutput(name, d_out & 32'h2, 32'h2);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    cs   = 1'b0;
    wr   = 1'b0;
    rd   = 1'b0;
    addr = 5'd0;
    d_in = 32'd0;
    rst  = 1'b1;

    vecs[0] = '{1'b1, A_DIVIDEND,  32'd100,        32'd0,   "wr_dividend"};
    vecs[1] = '{1'b1, A_DIVISOR,   32'd7,          32'd0,   "wr_divisor"};
    vecs[2] = '{1'b0, A_DIVIDEND,  32'd0,          32'd100, "rd_dividend"};
    vecs[3] = '{1'b0, A_DIVISOR,   32'd0,          32'd7,   "rd_divisor"};
    vecs[4] = '{1'b1, A_QUOTIENT,  32'h5555_5555,  32'd0,   "wr_quotient_ro"};
    vecs[5] = '{1'b0, A_QUOTIENT,  32'd0,          32'd0,   "rd_quotient_ro"};
    vecs[6] = '{1'b1, 5'h14,       32'hAAAA_AAAA,  32'd0,   "wr_unmapped"};
    vecs[7] = '{1'b0, 5'h14,       32'd0,          32'd0,   "rd_unmapped_14"};
    vecs[8] = '{1'b1, A_CTRL,      32'd0,          32'd0,   "wr_ctrl_zero"};
    vecs[9] = '{1'b0, A_CTRL,      32'd0,          32'd0,   "rd_ctrl_idle"};

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_dout", d_out, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    read_check("reset_quotient", A_QUOTIENT, 32'd0);

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].is_wr)
        write_reg(vecs[i].a, vecs[i].data);
      else
        read_check(vecs[i].name, vecs[i].a, vecs[i].exp);
    end

    // 100 / 7: status must still read busy at edge T0+32 and done at T0+33.
    write_reg(A_CTRL, 32'd1);
    repeat (31) @(posedge clk);
    #1;
    read_check("t1_busy_last", A_CTRL, 32'h1);
    read_check("t1_done_first", A_CTRL, 32'h2);
    read_check("t1_quotient", A_QUOTIENT, 32'd14);
    read_check("t1_remainder", A_REMAINDER, 32'd2);

    // All-ones dividend, then a restart from DONE with a new divisor.
    write_reg(A_DIVIDEND, 32'hFFFF_FFFF);
    write_reg(A_DIVISOR, 32'd1);
    write_reg(A_CTRL, 32'd1);
    wait_done("t2a_done");
    read_check("t2a_quotient", A_QUOTIENT, 32'hFFFF_FFFF);
    read_check("t2a_remainder", A_REMAINDER, 32'd0);
    write_reg(A_DIVISOR, 32'hFFFF_FFFF);
    write_reg(A_CTRL, 32'd1);
    read_check("t2b_busy", A_CTRL, 32'h1);
    wait_done("t2b_done");
    read_check("t2b_quotient", A_QUOTIENT, 32'd1);
    read_check("t2b_remainder", A_REMAINDER, 32'd0);

    // Divide by zero.
    write_reg(A_DIVIDEND, 32'd5);
    write_reg(A_DIVISOR, 32'd0);
    write_reg(A_CTRL, 32'd1);
    read_check("t3_running_div0", A_CTRL, 32'h5);
    wait_done("t3_done");
    read_check("t3_ctrl", A_CTRL, 32'h6);
    read_check("t3_quotient", A_QUOTIENT, 32'hFFFF_FFFF);
    read_check("t3_remainder", A_REMAINDER, 32'd5);

    // 1000 / 10 with a divisor write and an ignored start mid-operation.
    write_reg(A_DIVIDEND, 32'd1000);
    write_reg(A_DIVISOR, 32'd10);
    write_reg(A_CTRL, 32'd1);
    repeat (4) @(posedge clk);
    #1;
    write_reg(A_DIVISOR, 32'd3);
    write_reg(A_CTRL, 32'd1);
    repeat (25) @(posedge clk);
    #1;
    read_check("t4_busy_last", A_CTRL, 32'h1);
    read_check("t4_done_first", A_CTRL, 32'h2);
    read_check("t4_quotient", A_QUOTIENT, 32'd100);
    read_check("t4_remainder", A_REMAINDER, 32'd0);
    read_check("t4_divisor_rb", A_DIVISOR, 32'd3);

    // Reset in the middle of 12345 / 67.
    write_reg(A_DIVIDEND, 32'd12345);
    write_reg(A_DIVISOR, 32'd67);
    read_check("t5_dividend_rb", A_DIVIDEND, 32'd12345);
    write_reg(A_CTRL, 32'd1);
    repeat (9) @(posedge clk);
    rst = 1'b1;
    #1;
    checkOutput("t5_dout_async", d_out, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    read_check("t5_ctrl", A_CTRL, 32'd0);
    read_check("t5_quotient", A_QUOTIENT, 32'd0);
    read_check("t5_remainder", A_REMAINDER, 32'd0);
    read_check("t5_dividend", A_DIVIDEND, 32'd0);
    write_reg(A_DIVIDEND, 32'd12345);
    write_reg(A_DIVISOR, 32'd67);
    write_reg(A_CTRL, 32'd1);
    wait_done("t5_done");
    read_check("t5_quotient_new", A_QUOTIENT, 32'd184);
    read_check("t5_remainder_new", A_REMAINDER, 32'd17);

    // Deselected strobes, read-during-write, unmapped read.
    applyStimulus(1'b0, 1'b1, 1'b0, A_DIVIDEND, 32'd0);
    checkOutput("t6_nocs_read", d_out, 32'd17);
    applyStimulus(1'b1, 1'b0, 1'b0, A_DIVIDEND, 32'hDEAD_BEEF);
    read_check("t6_nocs_write", A_DIVIDEND, 32'd12345);
    applyStimulus(1'b1, 1'b1, 1'b1, A_DIVIDEND, 32'd777);
    checkOutput("t6_rdwr_old", d_out, 32'd12345);
    read_check("t6_rdwr_new", A_DIVIDEND, 32'd777);
    read_check("t6_unmapped_1c", 5'h1C, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
